// File: rtl/bit_serializer_pkg.sv
// Shared constants for the serializer and the downstream sequence recognizer bench.
package bit_serializer_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam int   DEFAULT_WIDTH    = 8;
   localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word holding buffer; drives the recognizer's x input.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             x,
   output logic             busy,
   output logic             word_done
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] hold_buf;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt;
   logic             accept;

   // The bit presented on x is always the leading end of the shift register.
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   always_comb begin
      accept  = load && ready;
      shifted = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
   end

   // ready doubles as the holding-buffer empty flag: buffer is valid while ready is low.
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state     <= S_IDLE;
         x         <= IDLE_BIT;
         ready     <= 1'b1;
         busy      <= 1'b0;
         word_done <= 1'b0;
         cnt       <= '0;
         shift_reg <= '0;
         // NOTE: hold_buf is a plain register, not a memory, so clearing it on reset is cheap.
         hold_buf  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  shift_reg <= data_in;
                  x         <= lead_bit(data_in);
                  cnt       <= '0;
                  busy      <= 1'b1;
                  word_done <= 1'b0;
                  state     <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (cnt == LAST) begin
                  cnt       <= '0;
                  word_done <= 1'b0;
                  if (!ready) begin
                     shift_reg <= hold_buf;
                     x         <= lead_bit(hold_buf);
                     hold_buf  <= '0;
                     ready     <= 1'b1;
                  end else if (load) begin
                     shift_reg <= data_in;
                     x         <= lead_bit(data_in);
                  end else begin
                     state <= S_IDLE;
                     x     <= IDLE_BIT;
                     busy  <= 1'b0;
                  end
               end else begin
                  shift_reg <= shifted;
                  x         <= lead_bit(shifted);
                  cnt       <= cnt + 1'b1;
                  word_done <= (cnt == LAST - 1'b1);
                  if (accept) begin
                     hold_buf <= data_in;
                     ready    <= 1'b0;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first default instance plus an LSB-first instance.
module tb_bit_serializer;

   logic       clk;
   logic       reset_;
   logic [7:0] data_in, data_l;
   logic       load, load_l;
   logic       ready, x, busy, word_done;
   logic       ready_l, x_l, busy_l, word_done_l;

   int checks   = 0;
   int failures = 0;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
      .clk(clk), .reset_(reset_), .data_in(data_in), .load(load),
      .ready(ready), .x(x), .busy(busy), .word_done(word_done)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
      .clk(clk), .reset_(reset_), .data_in(data_l), .load(load_l),
      .ready(ready_l), .x(x_l), .busy(busy_l), .word_done(word_done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0; load = 1'b0; data_in = '0; load_l = 1'b0; data_l = '0;
      #12;
      checks++;
      if ({x, ready, busy, word_done} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_hold: {x,ready,busy,word_done}=%b expected 1100", {x, ready, busy, word_done});
      end
      #3 reset_ = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({x, ready, busy, word_done} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_idle[%0d]: {x,ready,busy,word_done}=%b expected 1100", i, {x, ready, busy, word_done});
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] exp;
      exp = 8'b0010_0010;
      data_in = 8'h22; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({x, busy, word_done} !== {exp[7-i], 1'b1, (i == 7)}) begin
            failures++;
            $display("FAIL single[%0d]: {x,busy,word_done}=%b expected %b", i, {x, busy, word_done}, {exp[7-i], 1'b1, (i == 7)});
         end
         tick();
      end
      checks++;
      if ({x, busy, word_done, ready} !== 4'b1001) begin
         failures++;
         $display("FAIL single_idle: {x,busy,word_done,ready}=%b expected 1001", {x, busy, word_done, ready});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      logic        exp_rdy;
      exp = 16'b1010_0101_0011_1100;
      data_in = 8'hA5; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_rdy = !(i >= 1 && i <= 7);
         checks++;
         if ({x, busy, ready, word_done} !== {exp[15-i], 1'b1, exp_rdy, (i == 7 || i == 15)}) begin
            failures++;
            $display("FAIL b2b[%0d]: {x,busy,ready,word_done}=%b expected %b", i, {x, busy, ready, word_done}, {exp[15-i], 1'b1, exp_rdy, (i == 7 || i == 15)});
         end
         if (i == 0) begin data_in = 8'h3C; load = 1'b1; end
         else load = 1'b0;
         tick();
      end
      checks++;
      if ({x, busy} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_idle: {x,busy}=%b expected 10", {x, busy});
      end
   endtask

   task automatic test_bypass();
      logic [15:0] exp;
      exp = 16'b0000_1111_1111_0000;
      data_in = 8'h0F; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({x, busy, ready} !== {exp[15-i], 2'b11}) begin
            failures++;
            $display("FAIL bypass[%0d]: {x,busy,ready}=%b expected %b", i, {x, busy, ready}, {exp[15-i], 2'b11});
         end
         if (i == 7) begin data_in = 8'hF0; load = 1'b1; end
         else load = 1'b0;
         tick();
      end
      checks++;
      if ({x, busy} !== 2'b10) begin
         failures++;
         $display("FAIL bypass_idle: {x,busy}=%b expected 10", {x, busy});
      end
   endtask

   task automatic test_dropped();
      logic [15:0] exp;
      exp = 16'b1000_0001_0101_1010;
      data_in = 8'h81; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({x, busy} !== {exp[15-i], 1'b1}) begin
            failures++;
            $display("FAIL dropped[%0d]: {x,busy}=%b expected %b", i, {x, busy}, {exp[15-i], 1'b1});
         end
         if (i == 3 || i == 4) begin
            checks++;
            if (ready !== 1'b0) begin
               failures++;
               $display("FAIL dropped_ready[%0d]: ready=%b expected 0", i, ready);
            end
         end
         load = 1'b0;
         if (i == 1) begin data_in = 8'h5A; load = 1'b1; end
         if (i == 3) begin data_in = 8'hFF; load = 1'b1; end
         tick();
      end
      load = 1'b0;
      checks++;
      if ({x, busy, ready} !== 3'b101) begin
         failures++;
         $display("FAIL dropped_idle: {x,busy,ready}=%b expected 101", {x, busy, ready});
      end
   endtask

   task automatic test_reset_mid();
      data_in = 8'h00; load = 1'b1;
      tick();
      data_in = 8'h00; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      #2 reset_ = 1'b0;
      #1;
      checks++;
      if ({x, ready, busy, word_done} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_mid: {x,ready,busy,word_done}=%b expected 1100", {x, ready, busy, word_done});
      end
      #3 reset_ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({x, ready, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_mid_after[%0d]: {x,ready,busy}=%b expected 110", i, {x, ready, busy});
         end
      end
   endtask

   task automatic test_lsb();
      logic [15:0] exp;
      exp = 16'b1000_0000_0010_1101;
      data_l = 8'h01; load_l = 1'b1;
      tick();
      data_l = 8'hB4;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({x_l, busy_l, word_done_l} !== {exp[15-i], 1'b1, (i == 7 || i == 15)}) begin
            failures++;
            $display("FAIL lsb[%0d]: {x,busy,word_done}=%b expected %b", i, {x_l, busy_l, word_done_l}, {exp[15-i], 1'b1, (i == 7 || i == 15)});
         end
         tick();
         load_l = 1'b0;
      end
      checks++;
      if ({x_l, busy_l, ready_l} !== 3'b101) begin
         failures++;
         $display("FAIL lsb_idle: {x,busy,ready}=%b expected 101", {x_l, busy_l, ready_l});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      tick();
      test_back_to_back();
      tick();
      test_bypass();
      tick();
      test_dropped();
      tick();
      test_reset_mid();
      test_lsb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
